// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the one-cycle ALU
//   result path and the returned-load path. It also tracks registers that
//   are waiting on outstanding loads, so decode can stall on a hazard.
//
//   By default the ALU result has priority. A returned load that has been
//   refused for STARVE_LIMIT cycles in a row then takes priority. The write
//   port is registered, so rf_* reflect the transfer of the previous cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data      ALU write-back request
//   alu_ready                      ALU request accepted this cycle
//   ld_issue/ld_issue_rd           load dispatched; marks rd pending
//   ld_valid/ld_rd/ld_data         returned load write-back request
//   ld_ready                       returned load accepted this cycle
//   rs1, rs2                       decode-stage source registers
//   hazard                         a source waits on an outstanding load
//   rf_we/rf_rd/rf_wdata           registered register-file write port
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] pending_q, pending_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic ld_pri;
    logic alu_xfer, ld_xfer;

    // The priority mode is not stored as separate state. It is the starvation
    // counter reaching its saturation value.
    assign ld_pri = (starve_cnt_q == LIMIT);

    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!rst) begin
            if (ld_pri) begin
                ld_ready  = 1'b1;
                alu_ready = !ld_valid;
            end else begin
                alu_ready = 1'b1;
                ld_ready  = !alu_valid;
            end
        end
    end

    // The ready equations above never let both sides transfer in one cycle.
    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_valid && ld_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ld_valid || ld_xfer) begin
            starve_cnt_d = 3'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // A write to x0 still completes the handshake, but it is not a real
    // write. rf_rd and rf_wdata then keep the last real write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_xfer && alu_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = alu_rd;
            rf_wdata_d = alu_data;
        end else if (ld_xfer && ld_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = ld_rd;
            rf_wdata_d = ld_data;
        end
    end

    // The clear is applied before the set. When a new load to a register
    // issues as the old one retires, the register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (ld_xfer) begin
            pending_d[ld_rd] = 1'b0;
        end
        if (ld_issue && ld_issue_rd != 5'd0) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 3'd0;
            pending_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= 5'd0;
            rf_wdata_q   <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pending_q    <= pending_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    // pending_q[0] is always 0, so an x0 source never raises a hazard.
    // There is no forwarding: the bit clears in the same cycle that rf_we
    // carries the load.
    assign hazard = !rst && (pending_q[rs1] || pending_q[rs2]);

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: starvation count, outstanding-load set and
    // the expected write port.
    int          starve = 0;
    bit [31:0]   pend = '0;
    bit          m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wd = '0;
    bit          last_rst = 1'b0;

    // Values sampled in the last cycle, for the directed checks.
    logic s_alu_rdy, s_ld_rdy, s_haz;
    bit   ax, lx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the combinational outputs mid-cycle, advance
    // the model at the edge, then check the registered write port.
    task automatic cycle();
        bit ld_pri, e_ar, e_lr, e_hz;
        @(negedge clk);
        ld_pri = (starve >= LIMIT);
        e_ar = !rst && (!ld_pri || !ld_valid);
        e_lr = !rst && (ld_pri || !alu_valid);
        e_hz = !rst && ((rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]));
        s_alu_rdy = alu_ready;
        s_ld_rdy  = ld_ready;
        s_haz     = hazard;
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("ld_ready", 32'(ld_ready), 32'(e_lr));
        chk("hazard", 32'(hazard), 32'(e_hz));
        chk("one_xfer", 32'(alu_valid && alu_ready && ld_valid && ld_ready), 32'd0);
        ax = alu_valid && e_ar;
        lx = ld_valid && e_lr;
        @(posedge clk);
        if (rst) begin
            starve = 0; pend = '0; m_we = 0; m_rd = '0; m_wd = '0; last_rst = 1;
        end else begin
            last_rst = 0;
            m_we = 0;
            if (ax && alu_rd != 0) begin
                m_we = 1; m_rd = alu_rd; m_wd = alu_data;
            end else if (lx && ld_rd != 0) begin
                m_we = 1; m_rd = ld_rd; m_wd = ld_data;
            end
            if (!ld_valid || lx) starve = 0;
            else if (starve < LIMIT) starve++;
            if (lx) pend[ld_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1'b1;
        end
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        if (m_we || last_rst) begin
            chk("rf_rd", 32'(rf_rd), 32'(m_rd));
            chk("rf_wdata", rf_wdata, m_wd);
        end
    endtask

    initial begin
        // Reset with both requests valid: neither side may be accepted.
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid = 1; ld_rd = 5'd4; ld_data = 32'h22;
        cycle();
        chk("rst_alu_rdy", 32'(s_alu_rdy), 32'd0);
        chk("rst_ld_rdy", 32'(s_ld_rdy), 32'd0);
        cycle();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        rst = 0; alu_valid = 0; ld_valid = 0;
        cycle();

        // ALU only
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_only_rdy", 32'(s_alu_rdy), 32'd1);
        chk("alu_only_we", 32'(rf_we), 32'd1);
        chk("alu_only_rd", 32'(rf_rd), 32'd5);
        chk("alu_only_wd", rf_wdata, 32'hDEADBEEF);

        // Contention with a limit of 2: the load wins in its third cycle.
        alu_rd = 5'd1; alu_data = 32'hA1;
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77;
        cycle();
        chk("cont_ld_n0", 32'(s_ld_rdy), 32'd0);
        cycle();
        chk("cont_ld_n1", 32'(s_ld_rdy), 32'd0);
        cycle();
        chk("cont_ld_n2", 32'(s_ld_rdy), 32'd1);
        chk("cont_alu_n2", 32'(s_alu_rdy), 32'd0);
        chk("cont_rd_n3", 32'(rf_rd), 32'd7);
        chk("cont_wd_n3", rf_wdata, 32'h77);
        ld_valid = 0;
        cycle();
        chk("cont_alu_n3", 32'(s_alu_rdy), 32'd1);
        chk("cont_rd_n4", 32'(rf_rd), 32'd1);

        // Scoreboard hazard lifetime
        alu_valid = 0; ld_issue = 1; ld_issue_rd = 5'd9;
        cycle();
        ld_issue = 0; rs1 = 5'd9;
        cycle();
        chk("sb_haz_a", 32'(s_haz), 32'd1);
        cycle();
        chk("sb_haz_b", 32'(s_haz), 32'd1);
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99;
        cycle();
        chk("sb_haz_m", 32'(s_haz), 32'd1);
        chk("sb_we_m1", 32'(rf_we), 32'd1);
        chk("sb_rd_m1", 32'(rf_rd), 32'd9);
        ld_valid = 0;
        cycle();
        chk("sb_haz_m1", 32'(s_haz), 32'd0);

        // x0 destination
        rs1 = 5'd0;
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        cycle();
        chk("x0_alu_rdy", 32'(s_alu_rdy), 32'd1);
        chk("x0_we", 32'(rf_we), 32'd0);
        alu_valid = 0; ld_issue = 1; ld_issue_rd = 5'd0;
        cycle();
        ld_issue = 0;
        cycle();
        chk("x0_haz", 32'(s_haz), 32'd0);

        // Same-cycle set and clear of x3
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h33;
        ld_issue = 1; ld_issue_rd = 5'd3;
        cycle();
        ld_valid = 0; ld_issue = 0; rs2 = 5'd3;
        cycle();
        chk("collide_haz", 32'(s_haz), 32'd1);

        // Reset in the middle of contention
        rs2 = 5'd0;
        ld_issue = 1; ld_issue_rd = 5'd4;
        cycle();
        ld_issue = 0;
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
        ld_valid = 1; ld_rd = 5'd5; ld_data = 32'h55;
        cycle();
        rst = 1; rs1 = 5'd4;
        cycle();
        chk("mid_rst_alu", 32'(s_alu_rdy), 32'd0);
        chk("mid_rst_ld", 32'(s_ld_rdy), 32'd0);
        chk("mid_rst_haz", 32'(s_haz), 32'd0);
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_rd", 32'(rf_rd), 32'd0);
        chk("mid_rst_wd", rf_wdata, 32'd0);
        rst = 0;
        cycle();
        chk("post_rst_haz", 32'(s_haz), 32'd0);
        chk("post_rst_alu", 32'(s_alu_rdy), 32'd1);
        chk("post_rst_ld0", 32'(s_ld_rdy), 32'd0);
        cycle();
        chk("post_rst_ld1", 32'(s_ld_rdy), 32'd0);
        cycle();
        chk("post_rst_ld2", 32'(s_ld_rdy), 32'd1);
        alu_valid = 0; ld_valid = 0;
        cycle();

        // Random traffic. Each source holds its request until it transfers.
        for (int i = 0; i < 600; i++) begin
            if (!alu_valid || ax) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            if (!ld_valid || lx || last_rst) begin
                ld_valid = ($urandom_range(0, 99) < 45);
                ld_rd    = 5'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            ld_issue    = ($urandom_range(0, 99) < 30);
            ld_issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) < 2);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2, max consecutive cycles a valid load may be refused before it wins the port (range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  single-cycle result (ALU/JAL/LUI select) ready for write-back.
REQ-005 alu_rd  input  5  destination register of ALU result.
REQ-006 alu_data  input  32  ALU-path write-back data.
REQ-007 alu_ready  output  1  arbiter accepts ALU result this cycle.
REQ-008 ld_issue  input  1  load dispatched to data memory this cycle.
REQ-009 ld_issue_rd  input  5  destination of dispatched load.
REQ-010 ld_valid  input  1  load data returned and waiting.
REQ-011 ld_rd  input  5  destination of returned load.
REQ-012 ld_data  input  32  returned load data (already sign/zero extended).
REQ-013 ld_ready  output  1  arbiter accepts returned load this cycle.
REQ-014 rs1, rs2  input  5 each  source registers of instruction in decode.
REQ-015 hazard  output  1  a source register awaits an outstanding load.
REQ-016 rf_we, rf_rd, rf_wdata  output  1/5/32  register-file write port, registered.

Function
REQ-017 Handshake: transfer on a side occurs when valid && ready in same cycle; valid/rd/data shall be held stable by the source until transfer.
REQ-018 Arbitration mode ALU_PRI (starve_cnt < STARVE_LIMIT): alu_ready = 1; ld_ready = !alu_valid.
REQ-019 Mode LD_PRI (starve_cnt == STARVE_LIMIT): ld_ready = 1; alu_ready = !ld_valid.
REQ-020 starve_cnt (3 bits): +1 each cycle ld_valid && !ld_ready; cleared on load transfer or when ld_valid = 0; saturates at STARVE_LIMIT.
REQ-021 At most one transfer per cycle; alu_ready and ld_ready shall never both be 1 while both valids are 1.
REQ-022 Latency: transfer in cycle N -> rf_we = 1, rf_rd, rf_wdata of that transfer in cycle N+1; otherwise rf_we = 0 in N+1, rf_rd/rf_wdata hold last values.
REQ-023 Transfer with rd = 0 completes handshake normally but rf_we stays 0 in N+1.
REQ-024 Scoreboard: 32-bit pending vector, bit 0 hardwired 0.
REQ-025 ld_issue with ld_issue_rd != 0 sets pending[ld_issue_rd] at next edge.
REQ-026 Load transfer clears pending[ld_rd] at next edge.
REQ-027 Same-cycle set and clear of same register: set wins (bit remains 1).
REQ-028 ALU transfers do not modify the scoreboard.
REQ-029 hazard combinational = pending[rs1] | pending[rs2]; rs1/rs2 = 0 never contributes.
REQ-030 hazard shall not include write-back forwarding: bit cleared at edge after transfer, so hazard drops the cycle rf_we asserts.

Reset
REQ-031 While rst = 1: alu_ready = 0, ld_ready = 0, hazard = 0, no transfer accepted.
REQ-032 Edge with rst = 1: rf_we, rf_rd, rf_wdata, starve_cnt, pending all cleared to 0; mode returns to ALU_PRI.
REQ-033 Reset mid-operation discards an in-flight pending register write; a load held valid across reset is accepted normally after rst deasserts.

Verification
REQ-034 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF cycle N -> alu_ready=1 N, rf_we=1 rd=5 wdata=0xDEADBEEF N+1.
REQ-035 Contention, LIMIT=2: alu_valid held 1, ld_valid=1 rd=7 from cycle N -> ld_ready 0 at N, N+1; ld_ready=1, alu_ready=0 at N+2; rf_we rd=7 at N+3; ALU resumes N+3.
REQ-036 Scoreboard: ld_issue rd=9 cycle N; rs1=9 at N+1 -> hazard=1 until load transfer at M; hazard=0 from M+1; rf_we rd=9 at M+1.
REQ-037 x0: ALU transfer rd=0 data=0x1234 -> alu_ready=1, rf_we=0 next cycle; ld_issue rd=0 -> hazard stays 0 with rs1=0.
REQ-038 Set/clear collision: load transfer rd=3 and ld_issue rd=3 same cycle -> pending[3]=1 after edge, hazard=1 with rs2=3.
REQ-039 Reset mid-contention: starve_cnt=1, pending[4]=1, assert rst one cycle -> all outputs 0, hazard=0 with rs1=4, ALU_PRI after release.
